readpoly_fsm: RTL and testbench
===============================

Name: readpoly_fsm

Overview:
Read-side controller for the polynomial coefficient RAM. On `start` it reads coefficients 0..len-1 from the RAM and streams them out over a valid/ready interface. It absorbs the RAM read latency and downstream back-pressure with a small internal FIFO. It pulses `done` after the last coefficient is accepted, and serves as the drain/export path for polynomial buffers that the write-side control FSMs fill or clear.

Parameters:
- ADDR_W, 11, coefficient index and RAM address width (covers p=761).
- DATA_W, 13, coefficient width (covers q=4591).
- RD_LAT, 1, RAM read latency in cycles from `mem_re` to valid `mem_rdata`; legal range 1..3.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a read-out; sampled only in IDLE.
- len, input, ADDR_W, number of coefficients to read; sampled with `start`.
- busy, output, 1, high whenever state != IDLE.
- mem_re, output, 1, RAM read enable.
- mem_addr, output, ADDR_W, RAM read address.
- mem_rdata, input, DATA_W, RAM read data; valid exactly RD_LAT cycles after `mem_re`.
- out_valid, output, 1, `out_data` holds a coefficient.
- out_ready, input, 1, downstream accepts; a beat transfers when out_valid & out_ready.
- out_data, output, DATA_W, coefficient at FIFO head.
- out_last, output, 1, high with the final coefficient (index len-1).
- done, output, 1, one-cycle pulse at end of read-out.

Behaviour:

Reset (async, rst_n=0):
- state=IDLE; rd_cnt, out_cnt, len_q and FIFO pointers/count cleared; in-flight read pipeline cleared.
- busy, mem_re, out_valid, out_last and done all 0; mem_addr=0.
- A reset mid-operation aborts immediately. No beat may be emitted until the next `start`.

Internal registers:
- rd_cnt: reads issued.
- out_cnt: beats transferred.
- inflight: reads issued whose data has not yet returned (0..RD_LAT).
- FIFO: depth RD_LAT+2, count 0..RD_LAT+2.

States (registered, 2 bits):
- IDLE:
  - start=1 and len!=0: latch len_q=len, clear counters, go to READ.
  - start=1 and len==0: go to DONE (no reads, no beats).
  - Otherwise stay in IDLE.
- READ:
  - mem_re = (rd_cnt < len_q) & (fifo_count + inflight < RD_LAT+2), using registered values only.
  - mem_addr = rd_cnt; rd_cnt increments on each issued read.
  - When rd_cnt == len_q (registered), go to DRAIN.
- DRAIN:
  - mem_re=0.
  - Go to DONE on the cycle the beat with out_last transfers.
- DONE:
  - done=1 for exactly one cycle, busy=1, then go to IDLE.

Data path and output handshake:
- Returned data is pushed into the FIFO RD_LAT cycles after its `mem_re`, in issue order.
- The credit check guarantees the FIFO never overflows; a push into a full FIFO is a design error (bench assertion).
- out_valid = fifo_count != 0; out_data = FIFO head.
- out_data must hold stable while out_valid & !out_ready.
- out_last = out_valid & (out_cnt == len_q-1).
- Simultaneous push and pop in the same cycle: count unchanged, both take effect.

Timing rules:
- Throughput: with out_ready held at 1, one beat per cycle sustained.
- First out_valid appears RD_LAT+1 cycles after the IDLE->READ transition.
- Because RD_LAT ≥ 1, the last beat always transfers in DRAIN.

Counters and boundary cases:
- Counters are ADDR_W bits wide and never wrap, since len ≤ 2^ADDR_W-1.
- len is ignored outside IDLE; changing it mid-run has no effect.
- start while busy is ignored.
- start held high through DONE re-triggers only after the return to IDLE.

Test Plan:
1. RD_LAT=1, RAM[k]=k+100, len=761, out_ready=1:
   - Expect 761 beats on consecutive cycles, data 100..860.
   - out_last only on data 860.
   - done pulses one cycle after the last beat; busy falls with return to IDLE.
2. len=5, out_ready toggling 1,0,0,1,…:
   - Data order 100..104 with none lost or duplicated.
   - out_data stable during stalls.
   - mem_re never issued when fifo_count+inflight=3.
3. len=0 start:
   - No mem_re and no out_valid; busy high 1 cycle (DONE) with done=1; back in IDLE next cycle.
4. len=1:
   - Single beat, data 100, with out_valid & out_last together; done follows.
5. RD_LAT=3, len=16, out_ready=0 for 20 cycles then 1:
   - Reads stall at 5 outstanding (fifo+inflight=5).
   - All 16 values then stream in order; FIFO overflow assertion never fires.
6. Reset mid-stream at beat 300 of len=761:
   - mem_re, out_valid and done drop immediately; state IDLE.
   - A new start with len=3 yields data 100..102 only.

Source files
------------

// File: rtl/readpoly_fsm.sv
// ---------------------------------------------------------------------------
// readpoly_fsm
//
// Read-side controller for the polynomial coefficient RAM. A start request
// reads coefficients 0..len-1 from the RAM and streams them out over a
// valid/ready interface. A small FIFO (RD_LAT+2 entries) absorbs the RAM read
// latency and downstream back-pressure. Reads are only issued while the FIFO
// has room for every read still in flight, so the FIFO cannot overflow.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, len       start a read-out of len coefficients (sampled in IDLE)
//   busy             high whenever the controller is not idle
//   mem_re, mem_addr RAM read request (combinational from registered state)
//   mem_rdata        RAM read data, valid RD_LAT cycles after mem_re
//   out_valid, out_ready, out_data, out_last   output stream
//   done             one-cycle pulse at the end of a read-out
// ---------------------------------------------------------------------------
module readpoly_fsm #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 13,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    // Wide enough to hold fifo count + inflight without overflow.
    localparam int CW    = $clog2(2 * DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rd_cnt_q;
    logic [ADDR_W-1:0] out_cnt_q;
    logic [ADDR_W-1:0] len_q;

    // Bit i set: a read was issued i+1 cycles ago; the top bit marks the
    // cycle in which its data is present on mem_rdata.
    logic [RD_LAT-1:0] re_pipe_q, re_pipe_d;

    logic [DATA_W-1:0] fifo_mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]     inflight;
    logic              push;
    logic              pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(re_pipe_q[i]);
        end
    end

    // Credit check: fifo entries plus reads in flight never exceed DEPTH.
    assign mem_re    = (state_q == S_READ) && (rd_cnt_q < len_q) &&
                       ((fifo_cnt_q + inflight) < CW'(DEPTH));
    assign mem_addr  = rd_cnt_q;
    assign push      = re_pipe_q[RD_LAT-1];
    assign out_valid = (fifo_cnt_q != '0);
    assign out_data  = fifo_mem_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (out_cnt_q == (len_q - ADDR_W'(1)));
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_comb begin
        re_pipe_d    = re_pipe_q << 1;
        re_pipe_d[0] = mem_re;
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Read pipeline tracking and FIFO control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_pipe_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            re_pipe_q  <= re_pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

    // Control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            len_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            len_q     <= len;
                            rd_cnt_q  <= '0;
                            out_cnt_q <= '0;
                            state_q   <= S_READ;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    if (mem_re) begin
                        rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
                    end
                    if (pop) begin
                        out_cnt_q <= out_cnt_q + ADDR_W'(1);
                    end
                    if (rd_cnt_q == len_q) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop) begin
                        out_cnt_q <= out_cnt_q + ADDR_W'(1);
                        if (out_last) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_readpoly_fsm.sv
// ---------------------------------------------------------------------------
// tb_readpoly_fsm
//
// Two instances share one clock: unit 0 with RD_LAT=1, unit 1 with RD_LAT=3.
// Each has a behavioural RAM with the matching latency and a cycle-level
// reference model (expected beat index, reads issued, outstanding credit)
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_readpoly_fsm;

    localparam int AW = 11;
    localparam int DW = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n     [2];
    logic          start     [2];
    logic [AW-1:0] len_s     [2];
    logic          busy      [2];
    logic          mem_re    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_rdata [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [DW-1:0] out_data  [2];
    logic          out_last  [2];
    logic          done      [2];

    logic [DW-1:0] ram [2][2048];

    readpoly_fsm #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .len(len_s[0]),
        .busy(busy[0]), .mem_re(mem_re[0]), .mem_addr(mem_addr[0]),
        .mem_rdata(mem_rdata[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .done(done[0])
    );

    readpoly_fsm #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .len(len_s[1]),
        .busy(busy[1]), .mem_re(mem_re[1]), .mem_addr(mem_addr[1]),
        .mem_rdata(mem_rdata[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .done(done[1])
    );

    // Behavioural RAMs; data bus shows all-ones when no read is returning.
    logic [AW-1:0] ap0 = '0;
    logic          vp0 = 1'b0;
    logic [AW-1:0] ap1 [3];
    logic [2:0]    vp1 = '0;
    initial for (int i = 0; i < 3; i++) ap1[i] = '0;

    always @(posedge clk) begin
        ap0    <= mem_addr[0];
        vp0    <= mem_re[0];
        ap1[0] <= mem_addr[1];
        ap1[1] <= ap1[0];
        ap1[2] <= ap1[1];
        vp1    <= {vp1[1:0], mem_re[1]};
    end
    assign mem_rdata[0] = vp0    ? ram[0][ap0]    : '1;
    assign mem_rdata[1] = vp1[2] ? ram[1][ap1[2]] : '1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 running, 2 done pulse
    int            phase      [2] = '{0, 0};
    int            issued     [2] = '{0, 0};
    int            xfer       [2] = '{0, 0};
    int            runlen     [2] = '{0, 0};
    bit            prev_stall [2] = '{0, 0};
    logic [DW-1:0] prev_data  [2];

    task automatic mon(input int u);
        int dep;
        int outst;
        bit ok;
        dep   = (u == 0) ? 3 : 5;
        outst = issued[u] - xfer[u];
        ok    = 1'b0;
        if (!rst_n[u]) begin
            chk(!busy[u] && !mem_re[u] && !out_valid[u] && !out_last[u] && !done[u] &&
                mem_addr[u] == '0, "reset_outputs",
                {busy[u], mem_re[u], out_valid[u], out_last[u], done[u]}, 0);
            phase[u] = 0; issued[u] = 0; xfer[u] = 0; prev_stall[u] = 1'b0;
            return;
        end
        chk(busy[u] == (phase[u] != 0), "busy", busy[u], phase[u] != 0);
        chk(done[u] == (phase[u] == 2), "done", done[u], phase[u] == 2);
        if (mem_re[u]) begin
            chk(phase[u] == 1 && issued[u] < runlen[u], "re_window", issued[u], runlen[u]);
            chk(outst < dep, "re_credit", outst, dep - 1);
            chk(mem_addr[u] == AW'(issued[u]), "mem_addr", mem_addr[u], issued[u]);
            issued[u]++;
        end
        if (prev_stall[u])
            chk(out_valid[u] && out_data[u] == prev_data[u], "stall_hold", out_data[u], prev_data[u]);
        if (out_valid[u]) begin
            ok = (phase[u] == 1) && (xfer[u] < runlen[u]);
            chk(ok, "valid_window", xfer[u], runlen[u]);
            if (ok) begin
                chk(out_data[u] == ram[u][xfer[u]], "out_data", out_data[u], ram[u][xfer[u]]);
                chk(out_last[u] == (xfer[u] == runlen[u] - 1), "out_last", out_last[u],
                    xfer[u] == runlen[u] - 1);
            end
        end else begin
            chk(!out_last[u], "last_without_valid", out_last[u], 0);
        end
        prev_stall[u] = out_valid[u] && !out_ready[u];
        prev_data[u]  = out_data[u];
        case (phase[u])
            0: if (start[u]) begin
                runlen[u] = int'(len_s[u]);
                issued[u] = 0;
                xfer[u]   = 0;
                phase[u]  = (len_s[u] == '0) ? 2 : 1;
            end
            1: if (ok && out_ready[u]) begin
                xfer[u]++;
                if (xfer[u] == runlen[u]) phase[u] = 2;
            end
            default: phase[u] = 0;
        endcase
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ram(input int u, input bit rnd);
        for (int k = 0; k < 2048; k++)
            ram[u][k] = rnd ? DW'($urandom_range(0, 8190)) : DW'(k + 100);
    endtask

    task automatic wait_idle(input int u, input int budget);
        for (int n = 0; n < budget && busy[u]; n++) tick();
        chk(!busy[u], "idle_timeout", busy[u], 0);
    endtask

    typedef struct {
        int u;
        int len;
        int exp_first;   // cycle of first out_valid, cycle 1 = first after start edge
        int exp_done;    // cycle of done pulse
        int exp_last;    // data seen with out_last (-1: none)
    } vec_t;

    vec_t tbl [6];

    task automatic run_vec(input vec_t v);
        int first, dn, lastd, u;
        u = v.u; first = -1; dn = -1; lastd = -1;
        out_ready[u] = 1'b1;
        len_s[u] = AW'(v.len);
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
        len_s[u] = AW'($urandom_range(0, 2047));
        for (int n = 1; n <= v.exp_done + 20; n++) begin
            if (out_valid[u] && first < 0) first = n;
            if (out_valid[u] && out_last[u]) lastd = int'(out_data[u]);
            if (done[u]) begin
                dn = n;
                break;
            end
            tick();
        end
        chk(first == v.exp_first, "vec_first_valid", first, v.exp_first);
        chk(dn == v.exp_done, "vec_done_cycle", dn, v.exp_done);
        chk(lastd == v.exp_last, "vec_last_data", lastd, v.exp_last);
        tick();
        chk(!busy[u], "vec_idle_after_done", busy[u], 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected end before it", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, cnt_re;
        bit seen_done;
        logic [DW-1:0] got [3];

        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; start[u] = 1'b0; len_s[u] = '0; out_ready[u] = 1'b0;
            load_ram(u, 1'b0);
        end
        tbl[0] = '{0, 761, 3, 764, 860};
        tbl[1] = '{0, 1,   3, 4,   100};
        tbl[2] = '{0, 0,  -1, 1,   -1};
        tbl[3] = '{1, 16,  5, 21,  115};
        tbl[4] = '{1, 1,   5, 6,   100};
        tbl[5] = '{0, 5,   3, 8,   104};

        repeat (3) tick();
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        tick();

        foreach (tbl[i]) run_vec(tbl[i]);

        // out_ready toggling 1,0,0,1,... on a 5-beat read-out
        start[0] = 1'b1; len_s[0] = AW'(5);
        tick();
        start[0] = 1'b0;
        beats = 0; seen_done = 1'b0;
        for (int n = 0; n < 200 && !seen_done; n++) begin
            out_ready[0] = (n % 4 == 0) || (n % 4 == 3);
            if (out_valid[0] && out_ready[0]) beats++;
            if (done[0]) seen_done = 1'b1;
            else tick();
        end
        chk(seen_done, "toggle_done_seen", seen_done, 1);
        chk(beats == 5, "toggle_beats", beats, 5);
        out_ready[0] = 1'b1;
        wait_idle(0, 10);

        // RD_LAT=3: downstream stalled for 20 cycles, reads stop at 5 outstanding
        out_ready[1] = 1'b0; start[1] = 1'b1; len_s[1] = AW'(16);
        tick();
        start[1] = 1'b0;
        cnt_re = 0;
        for (int n = 0; n < 20; n++) begin
            if (mem_re[1]) cnt_re++;
            tick();
        end
        chk(cnt_re == 5, "stall_reads_issued", cnt_re, 5);
        chk(!mem_re[1] && out_valid[1], "stall_state", {mem_re[1], out_valid[1]}, 1);
        out_ready[1] = 1'b1;
        beats = 0; seen_done = 1'b0;
        for (int n = 0; n < 100 && !seen_done; n++) begin
            if (out_valid[1]) beats++;
            if (done[1]) seen_done = 1'b1;
            else tick();
        end
        chk(seen_done && beats == 16, "stall_all_beats", beats, 16);
        wait_idle(1, 10);

        // start held through DONE re-triggers only after the return to IDLE
        start[0] = 1'b1; len_s[0] = '0;
        tick();
        chk(done[0] && busy[0], "hold_done1", {done[0], busy[0]}, 3);
        tick();
        chk(!done[0] && !busy[0], "hold_idle", {done[0], busy[0]}, 0);
        tick();
        chk(done[0], "hold_done2", done[0], 1);
        start[0] = 1'b0;
        wait_idle(0, 10);

        // Reset in the middle of a long read-out
        out_ready[0] = 1'b1; start[0] = 1'b1; len_s[0] = AW'(761);
        tick();
        start[0] = 1'b0;
        beats = 0;
        for (int n = 0; n < 1000 && beats < 300; n++) begin
            if (out_valid[0]) beats++;
            if (beats < 300) tick();
        end
        chk(beats == 300, "reset_reach_beat300", beats, 300);
        rst_n[0] = 1'b0;
        #1;
        chk(!mem_re[0] && !out_valid[0] && !done[0] && !busy[0], "reset_immediate",
            {mem_re[0], out_valid[0], done[0], busy[0]}, 0);
        tick(); tick();
        rst_n[0] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk(!out_valid[0] && !mem_re[0], "post_reset_quiet", {out_valid[0], mem_re[0]}, 0);
        end
        start[0] = 1'b1; len_s[0] = AW'(3);
        tick();
        start[0] = 1'b0;
        beats = 0;
        for (int n = 0; n < 50 && busy[0]; n++) begin
            if (out_valid[0] && beats < 3) got[beats] = out_data[0];
            if (out_valid[0]) beats++;
            tick();
        end
        chk(beats == 3, "after_reset_beats", beats, 3);
        for (int k = 0; k < 3; k++)
            chk(beats == 3 && got[k] == DW'(100 + k), "after_reset_data", got[k], 100 + k);

        // Randomized runs against the reference model
        for (int it = 0; it < 40; it++) begin
            int u, p, l;
            u = it % 2;
            start[u] = 1'b0;
            out_ready[u] = 1'b1;
            wait_idle(u, 600);
            load_ram(u, 1'b1);
            p = $urandom_range(30, 100);
            l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            len_s[u] = AW'(l);
            start[u] = 1'b1;
            tick();
            start[u] = 1'b0;
            for (int c = 0; c < l * 4 + 40 && busy[u]; c++) begin
                out_ready[u] = ($urandom_range(0, 99) < p);
                start[u] = ($urandom_range(0, 15) == 0);
                len_s[u] = AW'($urandom_range(0, 20));
                tick();
            end
            start[u] = 1'b0;
            out_ready[u] = 1'b1;
            wait_idle(u, 600);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
